// File: rtl/adc_sample_avg.sv
// rtl/adc_sample_avg.sv - ADC measurement front-end: N-sample floor average, min, max, watchdog
//
// Ports:
//   CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//   MEAS_START   CPU measurement request level; a rising edge starts a measurement
//   ADC, ADC_RDY ADC data word and conversion-ready level; a word is taken on each RDY rise
//   BUSY         high while capturing
//   MEAS_DONE    sticky completion flag, cleared when MEAS_START drops
//   TIMEOUT      last measurement was ended by the watchdog
//   SAMPLE_CNT   samples captured in the current/last measurement
//   AVG_OUT, MIN_OUT, MAX_OUT  results of the last completed measurement
module adc_sample_avg #(
    parameter int CADC_WIDTH    = 10,
    parameter int LOG2_AVG      = 2,
    parameter int TIMEOUT_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MEAS_START,
    input  logic [CADC_WIDTH-1:0] ADC,
    input  logic                  ADC_RDY,
    output logic                  BUSY,
    output logic                  MEAS_DONE,
    output logic                  TIMEOUT,
    output logic [LOG2_AVG:0]     SAMPLE_CNT,
    output logic [CADC_WIDTH-1:0] AVG_OUT,
    output logic [CADC_WIDTH-1:0] MIN_OUT,
    output logic [CADC_WIDTH-1:0] MAX_OUT
);

    localparam int ACC_W = CADC_WIDTH + LOG2_AVG;
    localparam logic [LOG2_AVG:0] LAST_IDX = (LOG2_AVG + 1)'((1 << LOG2_AVG) - 1);
    // Watchdog value from which one more idle cycle reaches the limit 2**TIMEOUT_WIDTH-1.
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                   state, state_nxt;
    logic                     start_q, rdy_q;
    logic                     start_rise, rdy_rise;
    logic [ACC_W-1:0]         acc;
    logic [CADC_WIDTH-1:0]    min_r, max_r;
    logic [TIMEOUT_WIDTH-1:0] wd;
    logic                     last_sample, wd_expire;
    logic                     load_pend, timeout_pend;

    assign start_rise  = MEAS_START & ~start_q;
    assign rdy_rise    = ADC_RDY & ~rdy_q;
    assign last_sample = rdy_rise && (SAMPLE_CNT == LAST_IDX);
    // A sample in the same cycle always beats the watchdog.
    assign wd_expire   = !rdy_rise && (wd == WD_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rise) state_nxt = CAPTURE;
            CAPTURE: begin
                if (!MEAS_START)                    state_nxt = IDLE;
                else if (last_sample || wd_expire)  state_nxt = DONE;
            end
            DONE:    if (!MEAS_START) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == CAPTURE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            start_q      <= 1'b0;
            rdy_q        <= 1'b0;
            acc          <= '0;
            min_r        <= '0;
            max_r        <= '0;
            wd           <= '0;
            load_pend    <= 1'b0;
            timeout_pend <= 1'b0;
            MEAS_DONE    <= 1'b0;
            TIMEOUT      <= 1'b0;
            SAMPLE_CNT   <= '0;
            AVG_OUT      <= '0;
            MIN_OUT      <= '0;
            MAX_OUT      <= '0;
        end else begin
            // rdy_q tracks ADC_RDY every cycle, so an RDY already high at start is not a rise.
            start_q   <= MEAS_START;
            rdy_q     <= ADC_RDY;
            load_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        acc        <= '0;
                        SAMPLE_CNT <= '0;
                        wd         <= '0;
                        TIMEOUT    <= 1'b0;
                        MEAS_DONE  <= 1'b0;
                        min_r      <= '1;
                        max_r      <= '0;
                    end
                end
                CAPTURE: begin
                    if (MEAS_START) begin
                        if (rdy_rise) begin
                            acc        <= acc + ACC_W'(ADC);
                            SAMPLE_CNT <= SAMPLE_CNT + 1'b1;
                            wd         <= '0;
                            if (ADC < min_r) min_r <= ADC;
                            if (ADC > max_r) max_r <= ADC;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                        // Results are published one cycle later, after acc/min/max settle.
                        if (last_sample || wd_expire) begin
                            load_pend    <= 1'b1;
                            timeout_pend <= wd_expire;
                        end
                    end
                end
                DONE: begin
                    if (load_pend) begin
                        TIMEOUT <= timeout_pend;
                        if (timeout_pend) begin
                            AVG_OUT <= '0;
                            MIN_OUT <= '0;
                            MAX_OUT <= '0;
                        end else begin
                            AVG_OUT <= CADC_WIDTH'(acc >> LOG2_AVG);
                            MIN_OUT <= min_r;
                            MAX_OUT <= max_r;
                        end
                    end
                    MEAS_DONE <= MEAS_START;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_avg.sv
// tb/tb_adc_sample_avg.sv - scoreboard bench for adc_sample_avg
module tb_adc_sample_avg;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       meas_start = 1'b0;
    logic [9:0] adc = '0;
    logic       adc_rdy = 1'b0;
    logic       busy, meas_done, timeout;
    logic [2:0] sample_cnt;
    logic [9:0] avg_out, min_out, max_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int cnt;
        int to;
    } exp_t;

    exp_t exp_q[$];
    logic done_prev = 1'b0;

    always #5 clk = ~clk;

    adc_sample_avg #(.CADC_WIDTH(10), .LOG2_AVG(2), .TIMEOUT_WIDTH(4)) dut (
        .CLK(clk), .RST_N(rst_n), .MEAS_START(meas_start), .ADC(adc), .ADC_RDY(adc_rdy),
        .BUSY(busy), .MEAS_DONE(meas_done), .TIMEOUT(timeout), .SAMPLE_CNT(sample_cnt),
        .AVG_OUT(avg_out), .MIN_OUT(min_out), .MAX_OUT(max_out)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every rising edge of MEAS_DONE is a presented result.
    always @(negedge clk) begin
        if (rst_n && meas_done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_avg", int'(avg_out), e.avg);
                chk("sb_min", int'(min_out), e.mn);
                chk("sb_max", int'(max_out), e.mx);
                chk("sb_cnt", int'(sample_cnt), e.cnt);
                chk("sb_timeout", int'(timeout), e.to);
            end
        end
        done_prev = meas_done;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_meas();
        meas_start = 1'b1;
        tick(1);
    endtask

    // One RDY pulse: rise sampled on the first edge, low again after it.
    task automatic pulse(input int val);
        adc = 10'(val);
        adc_rdy = 1'b1;
        tick(1);
        adc_rdy = 1'b0;
        tick(1);
    endtask

    task automatic push(input int a, input int mn, input int mx, input int c, input int t);
        exp_t e;
        e.avg = a; e.mn = mn; e.mx = mx; e.cnt = c; e.to = t;
        exp_q.push_back(e);
    endtask

    initial begin
        tick(2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(meas_done), 0);
        chk("rst_avg", int'(avg_out), 0);
        chk("rst_cnt", int'(sample_cnt), 0);
        rst_n = 1'b1;
        tick(2);

        // 1: 100,200,300,401 -> avg 250
        push(250, 100, 401, 4, 0);
        start_meas();
        chk("t1_busy", int'(busy), 1);
        pulse(100); pulse(200); pulse(300);
        adc = 10'd401; adc_rdy = 1'b1;
        tick(1);
        chk("t1_done_not_yet", int'(meas_done), 0);
        adc_rdy = 1'b0;
        tick(1);
        chk("t1_done_latency", int'(meas_done), 1);
        tick(3);
        meas_start = 1'b0;
        tick(1);
        chk("t1_done_clear", int'(meas_done), 0);
        chk("t1_avg_hold", int'(avg_out), 250);
        tick(2);

        // 4: abort after 2 samples
        start_meas();
        pulse(7); pulse(9);
        meas_start = 1'b0;
        tick(1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(meas_done), 0);
        chk("t4_avg_keep", int'(avg_out), 250);
        tick(2);

        // 2: RDY already high at start; 10,20,30,43 -> floor(103/4)=25
        adc = 10'd999;
        adc_rdy = 1'b1;
        tick(2);
        start_meas();
        chk("t2_fresh_cnt", int'(sample_cnt), 0);
        tick(3);
        chk("t2_no_capture", int'(sample_cnt), 0);
        chk("t2_busy", int'(busy), 1);
        adc_rdy = 1'b0;
        tick(1);
        push(25, 10, 43, 4, 0);
        pulse(10); pulse(20); pulse(30); pulse(43);
        tick(2);
        meas_start = 1'b0;
        tick(2);

        // 3: one sample then stall -> watchdog after 15 idle cycles
        push(0, 0, 0, 1, 1);
        start_meas();
        pulse(5);
        tick(13);
        chk("t3_still_busy", int'(busy), 1);
        tick(1);
        chk("t3_left_capture", int'(busy), 0);
        chk("t3_done_pending", int'(meas_done), 0);
        tick(1);
        chk("t3_done", int'(meas_done), 1);
        meas_start = 1'b0;
        tick(2);

        // 5: full scale, then held start in DONE must not retrigger
        push(1023, 1023, 1023, 4, 0);
        start_meas();
        chk("t5_timeout_clr", int'(timeout), 0);
        pulse(1023); pulse(1023); pulse(1023); pulse(1023);
        tick(6);
        chk("t5_no_retrig_busy", int'(busy), 0);
        chk("t5_done_held", int'(meas_done), 1);
        meas_start = 1'b0;
        tick(1);
        chk("t5_done_clear", int'(meas_done), 0);
        chk("t5_avg_hold", int'(avg_out), 1023);
        tick(2);

        // 6: async reset mid-capture
        start_meas();
        pulse(50); pulse(60);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_cnt", int'(sample_cnt), 0);
        chk("t6_avg", int'(avg_out), 0);
        chk("t6_max", int'(max_out), 0);
        meas_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);
        chk("t6_idle", int'(busy), 0);

        // Normal measurement after reset: 1,2,3,4 -> floor(10/4)=2
        push(2, 1, 4, 4, 0);
        start_meas();
        pulse(4); pulse(1); pulse(3); pulse(2);
        tick(2);
        meas_start = 1'b0;
        tick(2);

        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
